// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully-connected layer: one MAC walks every neuron row of an
// external synchronous weight ROM, then ReLU-saturates each result into dataOut.
module fc_layer_seq #(
    parameter int dataWidth  = 8,
    parameter int fracBits   = 4,
    parameter int numInputs  = 16,
    parameter int numOutputs = 10,
    parameter int addrWidth  = $clog2(numOutputs*(numInputs+1)),
    parameter int accWidth   = 2*dataWidth+$clog2(numInputs+1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_i,
    input  logic [dataWidth*numInputs-1:0]   dataIn_i,
    output logic                             wRen_o,
    output logic [addrWidth-1:0]             wAddr_o,
    input  logic [dataWidth-1:0]             wData_i,
    output logic                             busy_o,
    output logic [dataWidth*numOutputs-1:0]  dataOut_o,
    output logic                             outValid_o
);

    localparam int cntWidth = $clog2(numInputs+2);
    localparam int nWidth   = $clog2(numOutputs+1);
    localparam int maxOut   = 2**(dataWidth-1)-1;

    typedef enum logic [1:0] {IDLE, MAC, LAST, WRITE} state_e;

    state_e                            state_q, state_d;
    logic [dataWidth*numInputs-1:0]    x_q, x_d;
    logic [nWidth-1:0]                 n_q, n_d;
    logic [cntWidth-1:0]               j_q, j_d;
    logic [addrWidth-1:0]              base_q, base_d;
    logic signed [accWidth-1:0]        acc_q, acc_d;
    logic [dataWidth*numOutputs-1:0]   out_q, out_d;
    logic                              valid_q, valid_d;

    logic [cntWidth-1:0]               jm1;
    logic signed [dataWidth-1:0]       x_sel;
    logic signed [2*dataWidth-1:0]     prod;
    logic signed [accWidth-1:0]        prod_ext;
    logic signed [accWidth-1:0]        bias_ext;
    logic signed [accWidth-1:0]        r;
    logic [dataWidth-1:0]              y;
    logic                              last_n;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_n = (n_q == nWidth'(numOutputs-1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_i) state_d = MAC;
            MAC:   if (j_q == cntWidth'(numInputs)) state_d = LAST;
            LAST:  state_d = WRITE;
            WRITE: state_d = last_n ? IDLE : MAC;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        wRen_o     = (state_q == MAC);
        busy_o     = (state_q != IDLE);
        wAddr_o    = base_q + addrWidth'(j_q);
        dataOut_o  = out_q;
        outValid_o = valid_q;
    end

    // ROM data lags the address by one cycle, so it pairs with x[j-1]
    assign jm1      = j_q - cntWidth'(1);
    assign x_sel    = x_q[int'(jm1)*dataWidth +: dataWidth];
    assign prod     = $signed(wData_i) * x_sel;
    assign prod_ext = {{(accWidth-2*dataWidth){prod[2*dataWidth-1]}}, prod};
    assign bias_ext = {{(accWidth-dataWidth){wData_i[dataWidth-1]}}, wData_i}
                      <<< fracBits;
    assign r        = acc_q >>> fracBits;

    always_comb begin
        if (r[accWidth-1]) begin
            y = '0;
        end else if (r > accWidth'(maxOut)) begin
            y = dataWidth'(maxOut);
        end else begin
            y = r[dataWidth-1:0];
        end
    end

    // Datapath next-state
    always_comb begin
        x_d     = x_q;
        n_d     = n_q;
        j_d     = j_q;
        base_d  = base_q;
        acc_d   = acc_q;
        out_d   = out_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d     = dataIn_i;
                    n_d     = '0;
                    j_d     = '0;
                    base_d  = '0;
                    acc_d   = '0;
                    valid_d = 1'b0;
                end
            end
            MAC: begin
                j_d = j_q + cntWidth'(1);
                if (j_q != '0) acc_d = acc_q + prod_ext;
            end
            LAST: begin
                acc_d = acc_q + bias_ext;
            end
            WRITE: begin
                out_d[int'(n_q)*dataWidth +: dataWidth] = y;
                acc_d = '0;
                j_d   = '0;
                if (last_n) begin
                    n_d     = '0;
                    base_d  = '0;
                    valid_d = 1'b1;
                end else begin
                    n_d    = n_q + nWidth'(1);
                    base_d = base_q + addrWidth'(numInputs+1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= '0;
            n_q     <= '0;
            j_q     <= '0;
            base_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            n_q     <= n_d;
            j_q     <= j_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

endmodule
